// File: rtl/control_unit_mc.sv
`timescale 1ns/1ps
// control_unit_mc: registered instruction decoder with a multi-cycle multiply path.
// Single-cycle classes issue one cycle after accept; a multiply parks the FSM in
// MUL and issues its result MUL_LAT cycles after accept.
//
// state | meaning
// IDLE  | accepting requests, single-cycle decode path
// MUL   | multiply in flight, counter running, no new requests taken
module control_unit_mc #(
    parameter int MUL_LAT = 4,
    parameter int EN_MUL  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       S_In,
    input  logic [1:0] Mode,
    input  logic [3:0] Op_Code,
    input  logic       Stall,
    input  logic       Flush,
    output logic       out_valid,
    output logic       Mem_R_En,
    output logic       Mem_W_En,
    output logic       WB_En,
    output logic       B,
    output logic       S_Out,
    output logic [3:0] Exe_CMD,
    output logic       Illegal,
    output logic       Busy
);

    typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       mul_s_q, mul_s_d;

    logic       out_valid_q, out_valid_d;
    logic       mem_r_q, mem_r_d;
    logic       mem_w_q, mem_w_d;
    logic       wb_q, wb_d;
    logic       b_q, b_d;
    logic       s_out_q, s_out_d;
    logic [3:0] exe_q, exe_d;
    logic       illegal_q, illegal_d;

    logic       accept;
    logic       is_mul;
    logic       cnt_term;

    logic       dec_mem_r, dec_mem_w, dec_wb, dec_b, dec_s, dec_illegal;
    logic [3:0] dec_exe;

    assign in_ready = !rst && !Flush && !Stall && (state_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (Mode == 2'b11) && (EN_MUL != 0);
    // The counter lands on 0 on the same edge that registers the result, so the
    // terminal compare is against 1; this gives issue exactly MUL_LAT cycles after accept.
    assign cnt_term = (state_q == MUL) && (cnt_q == 4'd1) && !Stall && !Flush;

    // Combinational decode of the single-cycle instruction classes.
    always_comb begin
        dec_mem_r   = 1'b0;
        dec_mem_w   = 1'b0;
        dec_wb      = 1'b0;
        dec_b       = 1'b0;
        dec_s       = S_In;
        dec_illegal = 1'b0;
        dec_exe     = 4'b0000;
        case (Mode)
            2'b00: begin
                dec_wb = 1'b1;
                case (Op_Code)
                    4'b1101: dec_exe = 4'b0001;
                    4'b1111: dec_exe = 4'b1001;
                    4'b0100: dec_exe = 4'b0010;
                    4'b0101: dec_exe = 4'b0011;
                    4'b0010: dec_exe = 4'b0100;
                    4'b0110: dec_exe = 4'b0101;
                    4'b0000: dec_exe = 4'b0110;
                    4'b1100: dec_exe = 4'b0111;
                    4'b0001: dec_exe = 4'b1000;
                    4'b1010: begin
                        dec_exe = 4'b0100;
                        dec_wb  = 1'b0;
                    end
                    4'b1000: begin
                        dec_exe = 4'b0110;
                        dec_wb  = 1'b0;
                    end
                    default: begin
                        dec_illegal = 1'b1;
                        dec_wb      = 1'b0;
                        dec_s       = 1'b0;
                    end
                endcase
            end
            2'b01: begin
                dec_exe   = 4'b0010;
                dec_mem_r = S_In;
                dec_wb    = S_In;
                dec_mem_w = !S_In;
            end
            2'b10: begin
                dec_b = 1'b1;
                dec_s = 1'b0;
            end
            default: begin
                // Only reached with multiply decode disabled.
                dec_illegal = 1'b1;
                dec_s       = 1'b0;
            end
        endcase
    end

    // State, counter and output register update; rst dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            mul_s_q     <= 1'b0;
            out_valid_q <= 1'b0;
            mem_r_q     <= 1'b0;
            mem_w_q     <= 1'b0;
            wb_q        <= 1'b0;
            b_q         <= 1'b0;
            s_out_q     <= 1'b0;
            exe_q       <= 4'd0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_s_q     <= mul_s_d;
            out_valid_q <= out_valid_d;
            mem_r_q     <= mem_r_d;
            mem_w_q     <= mem_w_d;
            wb_q        <= wb_d;
            b_q         <= b_d;
            s_out_q     <= s_out_d;
            exe_q       <= exe_d;
            illegal_q   <= illegal_d;
        end
    end

    // Next-state logic: enter MUL on an accepted multiply, leave on terminal count or Flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && is_mul) state_d = MUL;
            MUL:  if (Flush || cnt_term) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Multiply counter and captured S bit; Stall freezes the count.
    always_comb begin
        cnt_d   = cnt_q;
        mul_s_d = mul_s_q;
        if (Flush) begin
            cnt_d = 4'd0;
        end else if (accept && is_mul) begin
            cnt_d   = 4'(MUL_LAT - 1);
            mul_s_d = S_In;
        end else if (state_q == MUL && !Stall) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Output register next values: Flush clears, Stall holds, otherwise issue or go idle.
    always_comb begin
        out_valid_d = out_valid_q;
        mem_r_d     = mem_r_q;
        mem_w_d     = mem_w_q;
        wb_d        = wb_q;
        b_d         = b_q;
        s_out_d     = s_out_q;
        exe_d       = exe_q;
        illegal_d   = illegal_q;
        if (Flush || !Stall) begin
            out_valid_d = 1'b0;
            mem_r_d     = 1'b0;
            mem_w_d     = 1'b0;
            wb_d        = 1'b0;
            b_d         = 1'b0;
            s_out_d     = 1'b0;
            exe_d       = 4'd0;
            illegal_d   = 1'b0;
            if (!Flush && accept && !is_mul) begin
                out_valid_d = 1'b1;
                mem_r_d     = dec_mem_r;
                mem_w_d     = dec_mem_w;
                wb_d        = dec_wb;
                b_d         = dec_b;
                s_out_d     = dec_s;
                exe_d       = dec_exe;
                illegal_d   = dec_illegal;
            end else if (cnt_term) begin
                out_valid_d = 1'b1;
                wb_d        = 1'b1;
                s_out_d     = mul_s_q;
                exe_d       = 4'b1010;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign Mem_R_En  = mem_r_q;
    assign Mem_W_En  = mem_w_q;
    assign WB_En     = wb_q;
    assign B         = b_q;
    assign S_Out     = s_out_q;
    assign Exe_CMD   = exe_q;
    assign Illegal   = illegal_q;
    assign Busy      = (state_q == MUL);

endmodule

// File: tb/tb_control_unit_mc.sv
`timescale 1ns/1ps
// Testbench for control_unit_mc: scoreboard of expected decodes, one task per scenario.
module tb_control_unit_mc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       S_In = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic [3:0] Op_Code = 4'd0;
    logic       Stall = 1'b0;
    logic       Flush = 1'b0;

    logic       in_ready, out_valid, Mem_R_En, Mem_W_En, WB_En, B, S_Out, Illegal, Busy;
    logic [3:0] Exe_CMD;
    logic       nm_in_ready, nm_out_valid, nm_Mem_R_En, nm_Mem_W_En, nm_WB_En, nm_B;
    logic       nm_S_Out, nm_Illegal, nm_Busy;
    logic [3:0] nm_Exe_CMD;

    logic [9:0] obs, nm_obs;
    assign obs    = {Illegal, Mem_R_En, Mem_W_En, WB_En, B, S_Out, Exe_CMD};
    assign nm_obs = {nm_Illegal, nm_Mem_R_En, nm_Mem_W_En, nm_WB_En, nm_B, nm_S_Out, nm_Exe_CMD};

    int checks = 0;
    int failures = 0;
    logic [9:0] sb_q[$];
    logic [9:0] exp_v;

    control_unit_mc #(.MUL_LAT(4), .EN_MUL(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .S_In(S_In),
        .Mode(Mode), .Op_Code(Op_Code), .Stall(Stall), .Flush(Flush),
        .out_valid(out_valid), .Mem_R_En(Mem_R_En), .Mem_W_En(Mem_W_En), .WB_En(WB_En),
        .B(B), .S_Out(S_Out), .Exe_CMD(Exe_CMD), .Illegal(Illegal), .Busy(Busy)
    );

    control_unit_mc #(.MUL_LAT(4), .EN_MUL(0)) dut_nm (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nm_in_ready), .S_In(S_In),
        .Mode(Mode), .Op_Code(Op_Code), .Stall(Stall), .Flush(Flush),
        .out_valid(nm_out_valid), .Mem_R_En(nm_Mem_R_En), .Mem_W_En(nm_Mem_W_En),
        .WB_En(nm_WB_En), .B(nm_B), .S_Out(nm_S_Out), .Exe_CMD(nm_Exe_CMD),
        .Illegal(nm_Illegal), .Busy(nm_Busy)
    );

    always #5 clk = ~clk;

    // Reference decode: {Illegal, R, W, WB, B, S_Out, Exe_CMD[3:0]}.
    function automatic logic [9:0] ref_dec(input logic [1:0] mode, input logic [3:0] op,
                                           input logic s, input bit mul_en);
        logic [3:0] exe;
        logic       wb;
        logic       ok;
        exe = 4'd0; wb = 1'b1; ok = 1'b1;
        case (mode)
            2'b00: begin
                case (op)
                    4'b1101: exe = 4'b0001;
                    4'b1111: exe = 4'b1001;
                    4'b0100: exe = 4'b0010;
                    4'b0101: exe = 4'b0011;
                    4'b0010: exe = 4'b0100;
                    4'b0110: exe = 4'b0101;
                    4'b0000: exe = 4'b0110;
                    4'b1100: exe = 4'b0111;
                    4'b0001: exe = 4'b1000;
                    4'b1010: begin exe = 4'b0100; wb = 1'b0; end
                    4'b1000: begin exe = 4'b0110; wb = 1'b0; end
                    default: ok = 1'b0;
                endcase
                return ok ? {3'b000, wb, 1'b0, s, exe} : 10'b10_0000_0000;
            end
            2'b01:   return {1'b0, s, !s, s, 1'b0, s, 4'b0010};
            2'b10:   return 10'b00_0010_0000;
            default: return mul_en ? {5'b00010, s, 4'b1010} : 10'b10_0000_0000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [3:0] op, input logic s);
        in_valid = v; Mode = m; Op_Code = op; S_In = s;
    endtask

    task automatic test_reset();
        rst = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(1'b1, 2'b00, 4'b0100, 1'b1);
        step(); step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        checks++; if (obs !== 10'd0) begin failures++; $display("FAIL rst_ctrl: got %b want 0", obs); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", Busy); end
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        rst = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_dp_decode();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 2'b00, 4'(i), i[0]);
            sb_q.push_back(ref_dec(2'b00, 4'(i), i[0], 1'b1));
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dp_ready op=%0d: got %b want 1", i, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL dp_valid op=%0d: got %b want 1", i, out_valid); end
            exp_v = sb_q.pop_front();
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL dp_decode op=%0d: got %b want %b", i, obs, exp_v); end
        end
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dp_no_dup_valid: got %b want 0", out_valid); end
        checks++; if (obs !== 10'd0) begin failures++; $display("FAIL dp_no_dup_ctrl: got %b want 0", obs); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] modes[3];
        logic       ss[3];
        modes[0] = 2'b01; ss[0] = 1'b1;
        modes[1] = 2'b01; ss[1] = 1'b0;
        modes[2] = 2'b10; ss[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, modes[i], 4'($urandom_range(0, 15)), ss[i]);
            sb_q.push_back(ref_dec(modes[i], Op_Code, ss[i], 1'b1));
            step();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid %0d: got %b want 1", i, out_valid); end
            exp_v = sb_q.pop_front();
            checks++; if (obs !== exp_v) begin failures++; $display("FAIL b2b_decode %0d: got %b want %b", i, obs, exp_v); end
        end
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_mul();
        drive(1'b1, 2'b11, 4'd0, 1'b1);
        sb_q.push_back(ref_dec(2'b11, 4'd0, 1'b1, 1'b1));
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mul_accept_ready: got %b want 1", in_ready); end
        step();
        for (int k = 1; k <= 3; k++) begin
            drive(1'b1, 2'b00, 4'b0100, 1'b0);
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mul_ready t+%0d: got %b want 0", k, in_ready); end
            checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL mul_busy t+%0d: got %b want 1", k, Busy); end
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_early t+%0d: got %b want 0", k, out_valid); end
            step();
        end
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mul_issue_valid: got %b want 1", out_valid); end
        exp_v = sb_q.pop_front();
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL mul_issue: got %b want %b", obs, exp_v); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mul_done_busy: got %b want 0", Busy); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mul_no_dup: got %b want 0", out_valid); end
    endtask

    task automatic test_mul_stall();
        drive(1'b1, 2'b11, 4'd0, 1'b0);
        sb_q.push_back(ref_dec(2'b11, 4'd0, 1'b0, 1'b1));
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            Stall = (k == 2 || k == 3);
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mstall_early t+%0d: got %b want 0", k, out_valid); end
            checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL mstall_busy t+%0d: got %b want 1", k, Busy); end
            step();
        end
        Stall = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mstall_issue_valid: got %b want 1", out_valid); end
        exp_v = sb_q.pop_front();
        checks++; if (obs !== exp_v) begin failures++; $display("FAIL mstall_issue: got %b want %b", obs, exp_v); end
        step();
    endtask

    task automatic test_mul_flush();
        drive(1'b1, 2'b11, 4'd0, 1'b1);
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
        Flush = 1'b1; Stall = 1'b1;
        drive(1'b1, 2'b00, 4'b0100, 1'b1);
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b want 0", in_ready); end
        step();
        Flush = 1'b0; Stall = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b want 0", Busy); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_idle_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (out_valid !== 1'b0 || obs !== 10'd0) begin failures++; $display("FAIL flush_no_issue %0d: got %b/%b want 0", k, out_valid, obs); end
            step();
        end
    endtask

    task automatic test_stall_hold();
        logic [9:0] held;
        drive(1'b1, 2'b00, 4'b0100, 1'b1);
        sb_q.push_back(ref_dec(2'b00, 4'b0100, 1'b1, 1'b1));
        step();
        held = sb_q.pop_front();
        checks++; if (out_valid !== 1'b1 || obs !== held) begin failures++; $display("FAIL hold_first: got %b/%b want 1/%b", out_valid, obs, held); end
        Stall = 1'b1;
        drive(1'b1, 2'b00, 4'b1101, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_ready %0d: got %b want 0", k, in_ready); end
            step();
            checks++; if (out_valid !== 1'b1 || obs !== held) begin failures++; $display("FAIL hold_keep %0d: got %b/%b want 1/%b", k, out_valid, obs, held); end
        end
        Flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || obs !== 10'd0) begin failures++; $display("FAIL hold_flush: got %b/%b want 0/0", out_valid, obs); end
        Flush = 1'b0; Stall = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
    endtask

    task automatic test_no_mul();
        drive(1'b1, 2'b11, 4'd0, 1'b1);
        sb_q.push_back(ref_dec(2'b11, 4'd0, 1'b1, 1'b1));
        #1;
        checks++; if (nm_in_ready !== 1'b1) begin failures++; $display("FAIL nomul_ready: got %b want 1", nm_in_ready); end
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if (nm_out_valid !== 1'b1) begin failures++; $display("FAIL nomul_valid: got %b want 1", nm_out_valid); end
        checks++; if (nm_obs !== ref_dec(2'b11, 4'd0, 1'b1, 1'b0)) begin failures++; $display("FAIL nomul_illegal: got %b want %b", nm_obs, ref_dec(2'b11, 4'd0, 1'b1, 1'b0)); end
        checks++; if (nm_Busy !== 1'b0) begin failures++; $display("FAIL nomul_busy: got %b want 0", nm_Busy); end
        step();
        checks++; if (nm_out_valid !== 1'b0) begin failures++; $display("FAIL nomul_no_dup: got %b want 0", nm_out_valid); end
        step(); step();
        exp_v = sb_q.pop_front();
        checks++; if (out_valid !== 1'b1 || obs !== exp_v) begin failures++; $display("FAIL nomul_main_mul: got %b/%b want 1/%b", out_valid, obs, exp_v); end
        step();
    endtask

    task automatic test_rst_mid();
        drive(1'b1, 2'b11, 4'd0, 1'b1);
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
        rst = 1'b1; Stall = 1'b1; Flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || obs !== 10'd0) begin failures++; $display("FAIL rstmul_out: got %b/%b want 0/0", out_valid, obs); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmul_busy: got %b want 0", Busy); end
        rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rstmul_ready: got %b want 1", in_ready); end
        for (int k = 0; k < 5; k++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmul_no_issue %0d: got %b want 0", k, out_valid); end
        end
        drive(1'b1, 2'b00, 4'b0100, 1'b1);
        sb_q.push_back(ref_dec(2'b00, 4'b0100, 1'b1, 1'b1));
        step();
        exp_v = sb_q.pop_front();
        checks++; if (out_valid !== 1'b1 || obs !== exp_v) begin failures++; $display("FAIL rststall_pre: got %b/%b want 1/%b", out_valid, obs, exp_v); end
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        Stall = 1'b1; rst = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || obs !== 10'd0) begin failures++; $display("FAIL rststall_out: got %b/%b want 0/0", out_valid, obs); end
        rst = 1'b0; Stall = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rststall_ready: got %b want 1", in_ready); end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_dp_decode();
        test_back_to_back();
        test_mul();
        test_mul_stall();
        test_mul_flush();
        test_stall_hold();
        test_no_mul();
        test_rst_mid();
        checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover: got %0d entries want 0", sb_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_unit_mc.md
CONTROL_UNIT_MC -- requirements
Module: control_unit_mc

Interface
REQ-001 The block SHALL have parameter MUL_LAT, default 4, range 2..15: execute cycles a multiply occupies before its result issues.
REQ-002 The block SHALL have parameter EN_MUL, default 1: 1 enables Mode 2'b11 multiply decode, 0 treats Mode 2'b11 as illegal.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decode request valid this cycle.
REQ-006 in_ready  output  1  block accepts a request this cycle.
REQ-007 S_In  input  1  instruction S bit (L bit in memory mode).
REQ-008 Mode  input  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 multiply.
REQ-009 Op_Code  input  4  data-processing opcode.
REQ-010 Stall  input  1  downstream cannot take output; hold output register.
REQ-011 Flush  input  1  discard output register contents and abort any multiply in progress.
REQ-012 out_valid  output  1  output register holds a valid decoded instruction.
REQ-013 Mem_R_En, Mem_W_En, WB_En, B, S_Out  output  1 each  registered control signals.
REQ-014 Exe_CMD  output  4  registered ALU command.
REQ-015 Illegal  output  1  registered; decoded instruction was unrecognised.
REQ-016 Busy  output  1  high while in state MUL.

Function
REQ-017 A request SHALL be accepted on a cycle when in_valid and in_ready are both high; in_ready = !rst && !Flush && !Stall && state == IDLE.
REQ-018 An accepted non-multiply request SHALL appear on the outputs with out_valid=1 on the next cycle (latency 1).
REQ-019 Data-processing decode (Exe_CMD, WB_En) SHALL be:
- MOV 1101 -> 0001, 1
- MVN 1111 -> 1001, 1
- ADD 0100 -> 0010, 1
- ADC 0101 -> 0011, 1
- SUB 0010 -> 0100, 1
- SBC 0110 -> 0101, 1
- AND 0000 -> 0110, 1
- ORR 1100 -> 0111, 1
- EOR 0001 -> 1000, 1
- CMP 1010 -> 0100, 0
- TST 1000 -> 0110, 0
REQ-020 Any other data-processing opcode SHALL produce Illegal=1 with Mem_R_En, Mem_W_En, WB_En, B and Exe_CMD all 0.
REQ-021 Memory mode SHALL produce Exe_CMD=0010; S_In=1 gives Mem_R_En=1, WB_En=1 (load); S_In=0 gives Mem_W_En=1 (store).
REQ-022 Branch mode SHALL produce B=1, WB_En=0 and Exe_CMD=0000 (never X).
REQ-023 S_Out SHALL be the registered S_In of the decoded instruction, and 0 for branch and illegal instructions.
REQ-024 FSM states SHALL be IDLE and MUL, with the following transitions:
- IDLE->MUL on an accepted Mode 11 request when EN_MUL=1
- MUL->IDLE when the counter expires, or on Flush
REQ-025 On entry to MUL, a 4-bit counter SHALL load MUL_LAT-1 and decrement each cycle Stall is low; out_valid SHALL stay 0 meanwhile.
REQ-026 In the cycle the counter reads 0 with Stall low, the block SHALL load outputs Exe_CMD=1010, WB_En=1, S_Out=S_In captured at accept, out_valid=1, and return to IDLE; the multiply issues exactly MUL_LAT cycles after accept.
REQ-027 Stall=1 SHALL freeze the output register, the FSM and the counter.
REQ-028 Flush SHALL take priority over Stall and in_valid; on the next edge out_valid=0, all controls 0, state=IDLE, counter=0.
REQ-029 When out_valid=1, Stall=0 and no new request is accepted, the next cycle SHALL show out_valid=0 with all controls 0 (no duplicate issue).
REQ-030 Outputs SHALL be driven only from registers; no combinational path SHALL exist from inputs to outputs except in_ready.

Reset
REQ-031 While rst=1 at a clock edge: out_valid, all controls, Exe_CMD and Illegal SHALL be 0; state=IDLE; counter=0; in_ready=0.
REQ-032 Reset SHALL abort a multiply in progress with no issue afterwards; rst SHALL dominate Flush and Stall.

Verification
REQ-033 ADD (Mode 00, Op 0100, S 1), one-cycle accept -> next cycle out_valid=1, Exe_CMD=0010, WB_En=1, S_Out=1.
REQ-034 LDR (Mode 01, S 1) then STR (Mode 01, S 0) back-to-back -> consecutive cycles give {R,W,WB}=101, then 010.
REQ-035 MUL with MUL_LAT=4 accepted at cycle t -> in_ready=0 and Busy=1 for cycles t+1..t+3; out_valid=1, Exe_CMD=1010 at t+4.
REQ-036 MUL accepted, Stall=1 for 2 cycles mid-count -> issue delayed to t+6; Flush at t+2 instead -> no issue, IDLE at t+3.
REQ-037 Op 0011 (Mode 00) -> Illegal=1, WB_En=0, Exe_CMD=0000; with EN_MUL=0, Mode 11 -> Illegal=1, no MUL entry.
REQ-038 rst asserted during MUL and during Stall with out_valid=1 -> next edge all outputs 0, state IDLE; in_ready=1 the cycle after rst deasserts.
